// File: rtl/ann_weight_pkg.sv
// Shared constants and types for the weight-memory read path.
package ann_weight_pkg;

    localparam int WEIGHT_W      = 16;
    localparam int DEFAULT_DEPTH = 28;
    localparam int DEFAULT_AW    = 5;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE_ST
    } reader_state_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding {weight, source index, last flag} between the BRAM and the MAC.
module weight_skid_fifo #(
    parameter int DW = 16,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_index,
    input  logic          push_last,
    input  logic          pop,
    input  logic          flush,
    output logic [1:0]    count,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] head_index,
    output logic          head_last
);

    logic [DW-1:0] data_q  [2];
    logic [AW-1:0] index_q [2];
    logic [1:0]    last_q;
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count_q;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i]  <= '0;
                index_q[i] <= '0;
            end
            last_q  <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                data_q[wr_ptr]  <= push_data;
                index_q[wr_ptr] <= push_index;
                last_q[wr_ptr]  <= push_last;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count      = count_q;
    assign head_data  = data_q[rd_ptr];
    assign head_index = index_q[rd_ptr];
    assign head_last  = last_q[rd_ptr];

endmodule

// File: rtl/weight_bram_reader.sv
// Streams weights 0..DEPTH-1 from one weight BRAM to a neuron MAC, tolerating backpressure.
// w_valid/w_ready: a word transfers on every cycle both are high; while w_valid is high and
// w_ready is low the word (w_data, w_index, w_last) is held unchanged.
module weight_bram_reader
    import ann_weight_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW,
    parameter int DW    = WEIGHT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic [AW-1:0] bram_addr,
    output logic          bram_en,
    output logic          bram_we,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_do,
    output logic [DW-1:0] w_data,
    output logic          w_valid,
    input  logic          w_ready,
    output logic [AW-1:0] w_index,
    output logic          w_last,
    output logic          busy,
    output logic          done,
    output reader_state_t state_dbg
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    reader_state_t state;
    reader_state_t state_nxt;
    logic [AW-1:0] issue_cnt;
    logic [1:0]    fifo_count;
    logic          issue;
    logic          pop;
    logic          head_last;

    // The BRAM registers on the falling edge, so a read issued this cycle is in flight
    // only until the next rising edge, where it lands in the FIFO.
    assign pop = w_valid && w_ready;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                issue = (fifo_count < 2'd2) || pop;
                if (issue && (issue_cnt == LAST_ADDR)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && head_last) state_nxt = DONE_ST;
            end
            DONE_ST: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            issue     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter returns to zero after the last issue so the address never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (abort) begin
            issue_cnt <= '0;
        end else if (issue) begin
            issue_cnt <= (issue_cnt == LAST_ADDR) ? '0 : issue_cnt + 1'b1;
        end
    end

    weight_skid_fifo #(
        .DW(DW),
        .AW(AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (issue),
        .push_data  (bram_do),
        .push_index (issue_cnt),
        .push_last  (issue_cnt == LAST_ADDR),
        .pop        (pop),
        .flush      (abort),
        .count      (fifo_count),
        .head_data  (w_data),
        .head_index (w_index),
        .head_last  (head_last)
    );

    assign w_valid   = (fifo_count != 2'd0);
    assign w_last    = head_last && w_valid;
    assign bram_en   = issue;
    assign bram_addr = issue_cnt;
    assign bram_we   = 1'b0;
    assign bram_di   = '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE_ST);
    assign state_dbg = state;

endmodule

// File: tb/tb_weight_bram_reader.sv
// Self-checking bench for weight_bram_reader: timing table, scoreboarded stream, corner sequences.
module tb_weight_bram_reader;
    import ann_weight_pkg::*;

    localparam int DEPTH  = 28;
    localparam int AW     = 5;
    localparam int DW     = 16;
    localparam int DEPTH2 = 4;
    localparam int AW2    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start, abort, w_ready;
    logic [AW-1:0] bram_addr, w_index;
    logic          bram_en, bram_we, w_valid, w_last, busy, done;
    logic [DW-1:0] bram_di, bram_do, w_data;
    reader_state_t state_dbg;

    logic           start2, abort2, w_ready2;
    logic [AW2-1:0] bram_addr2, w_index2;
    logic           bram_en2, bram_we2, w_valid2, w_last2, busy2, done2;
    logic [DW-1:0]  bram_di2, bram_do2, w_data2;
    reader_state_t  state_dbg2;

    weight_bram_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_di(bram_di),
        .bram_do(bram_do), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
        .w_index(w_index), .w_last(w_last), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    weight_bram_reader #(.DEPTH(DEPTH2), .AW(AW2), .DW(DW)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .bram_addr(bram_addr2), .bram_en(bram_en2), .bram_we(bram_we2), .bram_di(bram_di2),
        .bram_do(bram_do2), .w_data(w_data2), .w_valid(w_valid2), .w_ready(w_ready2),
        .w_index(w_index2), .w_last(w_last2), .busy(busy2), .done(done2), .state_dbg(state_dbg2)
    );

    logic [DW-1:0] mem  [32];
    logic [DW-1:0] mem2 [4];

    // BRAM models: read data registered on the falling edge of the enable cycle.
    always @(negedge clk) if (bram_en) bram_do <= mem[bram_addr];
    always @(negedge clk) if (bram_en2) bram_do2 <= mem2[bram_addr2];

    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    logic [AW+DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pass();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), mem[i]});
    endtask

    // Scoreboard and hold-stability monitor for the DEPTH=28 instance.
    bit stall_q = 1'b0;
    logic [AW+DW:0] stall_word;
    logic [AW+DW-1:0] e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_q) begin
                chk("hold_valid", w_valid, 1);
                chk("hold_word", {w_last, w_index, w_data}, stall_word);
            end
            stall_q    = w_valid && !w_ready && !abort;
            stall_word = {w_last, w_index, w_data};
            if (w_valid && w_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL extra_word: got index %0d data 0x%0h, expected no word", w_index, w_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_word", {w_index, w_data}, e);
                    chk("stream_last", w_last, e[AW+DW-1:DW] == AW'(DEPTH - 1));
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_after_all", exp_q.size(), 0);
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic run_pass(input int pct, input int budget, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        start = 1'b1;
        w_ready = ($urandom_range(99) < pct);
        cyc();
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            w_ready = ($urandom_range(99) < pct);
            cyc();
            n++;
        end
        chk({name, "_done"}, done_cnt, d0 + 1);
        chk({name, "_drained"}, exp_q.size(), 0);
        #2;
        chk({name, "_idle"}, busy, 0);
        repeat (3) cyc();
        chk({name, "_single_done"}, done_cnt, d0 + 1);
    endtask

    typedef struct {
        int            cyc;
        logic          en;
        logic [AW-1:0] addr;
        logic          valid;
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
        logic          busy;
        logic          done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned seed;
        int c, d0, n;
        bit hit;
        seed = $urandom(32'd20240611);
        start = 0; abort = 0; w_ready = 0;
        start2 = 0; abort2 = 0; w_ready2 = 0;
        bram_do = '0; bram_do2 = '0;

        // cycle, en, addr, valid, idx, data, last, busy, done (START driven in cycle 0)
        tbl[0] = '{0,  0, 0,  0, 0,  0,   0, 0, 0};
        tbl[1] = '{1,  1, 0,  0, 0,  0,   0, 1, 0};
        tbl[2] = '{2,  1, 1,  1, 0,  100, 0, 1, 0};
        tbl[3] = '{3,  1, 2,  1, 1,  101, 0, 1, 0};
        tbl[4] = '{28, 1, 27, 1, 26, 126, 0, 1, 0};
        tbl[5] = '{29, 0, 0,  1, 27, 127, 1, 1, 0};
        tbl[6] = '{30, 0, 0,  0, 0,  0,   0, 1, 1};
        tbl[7] = '{31, 0, 0,  0, 0,  0,   0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", w_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", bram_en, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_di", bram_di, 0);
        chk("rst_out", {w_last, w_index, w_data}, 0);
        chk("rst_state", state_dbg, IDLE);
        chk("rst2_out", {busy2, done2, w_valid2, bram_en2, bram_we2, bram_di2}, 0);
        rst_n = 1'b1;
        cyc();
        mon_en = 1'b1;

        // Full pass with w_ready high, table of timing checkpoints.
        for (int i = 0; i < 32; i++) mem[i] = DW'(100 + i);
        expect_pass();
        d0 = done_cnt;
        c = 0;
        start = 1'b1;
        w_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            while (c < tbl[k].cyc) begin
                cyc();
                start = 1'b0;
                c++;
            end
            #2;
            chk($sformatf("t%0d_en", k), bram_en, tbl[k].en);
            if (tbl[k].en) chk($sformatf("t%0d_addr", k), bram_addr, tbl[k].addr);
            chk($sformatf("t%0d_valid", k), w_valid, tbl[k].valid);
            if (tbl[k].valid) begin
                chk($sformatf("t%0d_index", k), w_index, tbl[k].idx);
                chk($sformatf("t%0d_data", k), w_data, tbl[k].data);
                chk($sformatf("t%0d_last", k), w_last, tbl[k].last);
            end
            chk($sformatf("t%0d_busy", k), busy, tbl[k].busy);
            chk($sformatf("t%0d_done", k), done, tbl[k].done);
        end
        cyc();
        chk("full_done_cnt", done_cnt, d0 + 1);
        chk("full_drained", exp_q.size(), 0);

        // Backpressure while index 3 is at the head.
        expect_pass();
        d0 = done_cnt;
        start = 1'b1;
        w_ready = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (!(w_valid && w_index == 3) && n < 50) begin
            cyc();
            n++;
        end
        chk("bp_head3", w_index, 3);
        w_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #2;
            chk("bp_data", w_data, 103);
            chk("bp_en", bram_en, j == 0);
            cyc();
        end
        w_ready = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            #2;
            if (exp_q.size() > 0) chk("bp_no_gap", w_valid, 1);
            cyc();
            n++;
        end
        chk("bp_done", done_cnt, d0 + 1);
        chk("bp_drained", exp_q.size(), 0);
        repeat (2) cyc();

        // Random backpressure with signed extremes.
        for (int i = 0; i < 32; i++) mem[i] = DW'($urandom_range(16'hffff));
        mem[0] = 16'h0000;
        mem[3] = 16'h8000;
        mem[7] = 16'h7fff;
        mem[27] = 16'h8000;
        expect_pass();
        run_pass(50, 400, "rand");

        // Abort on the handshake of index 10, then a clean restart.
        expect_pass();
        d0 = done_cnt;
        start = 1'b1;
        w_ready = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 300) begin
            w_ready = 1'($urandom_range(1));
            if (w_valid && w_ready && w_index == 10) begin
                abort = 1'b1;
                hit = 1'b1;
            end
            cyc();
            n++;
        end
        abort = 1'b0;
        #2;
        chk("abort_hit", hit, 1);
        chk("abort_valid", w_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        repeat (4) cyc();
        chk("abort_no_done", done_cnt, d0);
        expect_pass();
        run_pass(100, 200, "restart");

        // Asynchronous reset in the middle of DRAIN.
        expect_pass();
        start = 1'b1;
        w_ready = 1'b1;
        cyc();
        start = 1'b0;
        n = 0;
        while (state_dbg != DRAIN && n < 100) begin
            cyc();
            n++;
        end
        chk("arst_in_drain", state_dbg, DRAIN);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", w_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_en", bram_en, 0);
        chk("arst_addr", bram_addr, 0);
        chk("arst_out", {w_last, w_index, w_data}, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        mon_en = 1'b1;
        expect_pass();
        run_pass(50, 400, "post_rst");

        // START while busy and in the DONE cycle must be ignored.
        expect_pass();
        d0 = done_cnt;
        start = 1'b1;
        w_ready = 1'b1;
        cyc();
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            start = (n == 4) || done;
            cyc();
            n++;
        end
        start = 1'b0;
        chk("restart_ignored_done", done_cnt, d0 + 1);
        chk("restart_ignored_drained", exp_q.size(), 0);
        for (int j = 0; j < 3; j++) begin
            #2;
            chk("no_extra_pass_busy", busy, 0);
            chk("no_extra_pass_en", bram_en, 0);
            cyc();
        end

        // START together with ABORT in IDLE starts nothing.
        start = 1'b1;
        abort = 1'b1;
        cyc();
        start = 1'b0;
        abort = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #2;
            chk("start_abort_busy", busy, 0);
            chk("start_abort_en", bram_en, 0);
            cyc();
        end
        chk("start_abort_no_done", done_cnt, d0 + 1);

        // DEPTH=4, AW=2 instance: full pass with w_ready high.
        for (int i = 0; i < 4; i++) mem2[i] = DW'($urandom_range(16'hffff));
        mem2[1] = 16'h8000;
        start2 = 1'b1;
        w_ready2 = 1'b1;
        cyc();
        start2 = 1'b0;
        for (c = 1; c <= 7; c++) begin
            #2;
            chk($sformatf("d4_c%0d_valid", c), w_valid2, (c >= 2) && (c <= 5));
            if ((c >= 2) && (c <= 5)) begin
                chk($sformatf("d4_c%0d_index", c), w_index2, c - 2);
                chk($sformatf("d4_c%0d_data", c), w_data2, mem2[c - 2]);
                chk($sformatf("d4_c%0d_last", c), w_last2, c == 5);
            end
            chk($sformatf("d4_c%0d_done", c), done2, c == 6);
            chk($sformatf("d4_c%0d_busy", c), busy2, c <= 6);
            cyc();
        end
        chk("d4_state_idle", state_dbg2, IDLE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/weight_bram_reader.md
Name: weight_bram_reader

Overview:
- Read-side sequencer for a single 16-bit signed weight BRAM (DEPTH entries, read data registered on falling CLK edge).
- On START, fetches addresses 0..DEPTH-1 in order and streams the weights to a neuron MAC over a valid/ready interface.
- Tolerates MAC backpressure with no loss or duplication.
- Sits between one Weight BRAM instance and its neuron's accumulate datapath. Never writes the BRAM.

Parameters:
- DEPTH, 28, number of weights read per pass (>=2).
- AW, 5, address width; 2**AW >= DEPTH.
- DW, 16, weight width (signed).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  1-cycle request to begin a pass; ignored while BUSY=1.
- ABORT  in  1  cancels the current pass; priority over START.
- BRAM_ADDR  out  AW  address to BRAM.
- BRAM_EN  out  1  BRAM enable, one read per asserted cycle.
- BRAM_WE  out  1  constant 0.
- BRAM_DI  out  DW  constant 0.
- BRAM_DO  in  DW  signed BRAM read data; valid at the rising edge after the EN cycle.
- W_DATA  out  DW  signed weight to MAC.
- W_VALID  out  1  W_DATA valid.
- W_READY  in  1  MAC accepts; a handshake occurs when W_VALID&W_READY.
- W_INDEX  out  AW  address the current W_DATA came from.
- W_LAST  out  1  high with index DEPTH-1.
- BUSY  out  1  pass in progress.
- DONE  out  1  1-cycle pulse after the final handshake.

Behaviour:
- Reset (RST_N=0, asynchronous): state IDLE.
  - All outputs 0; BRAM_ADDR=0.
  - FIFO empty; issue counter and in-flight flag cleared.
- FSM states and transitions:
  - IDLE: START -> FETCH.
  - FETCH: on the cycle the last address is issued -> DRAIN.
  - DRAIN: on the handshake of index DEPTH-1 -> DONE_ST.
  - DONE_ST: drives DONE=1 for one cycle -> IDLE.
  - BUSY=1 in FETCH, DRAIN and DONE_ST.
- Read issue:
  - In FETCH, BRAM_EN=1 with BRAM_ADDR=issue_cnt when (fifo_count + inflight) < 2, or when a pop occurs in the same cycle.
  - issue_cnt increments by 1 per issued read.
  - No read is issued beyond DEPTH-1 and there is no address wrap.
- Capture:
  - inflight is set on each issued read.
  - On the next rising edge, BRAM_DO and its address are pushed into a 2-entry FIFO.
  - Issue-to-push latency is 1 cycle. The FIFO never overflows because of the issue rule.
- Output side:
  - W_VALID = FIFO non-empty; W_DATA/W_INDEX/W_LAST come from the FIFO head.
  - While W_VALID=1 and W_READY=0, W_DATA, W_INDEX and W_LAST hold stable.
  - Simultaneous push and pop is allowed at any occupancy.
- Latency and throughput:
  - START sampled at edge 0 -> first BRAM_EN in cycle 1 -> W_VALID with index 0 in cycle 2.
  - With W_READY=1 throughout: one word per cycle, indices 0..DEPTH-1 on consecutive cycles, DONE in the cycle after index DEPTH-1.
- ABORT in any non-IDLE state:
  - Next cycle state=IDLE, FIFO flushed, in-flight read discarded, W_VALID=0, BUSY=0.
  - No DONE pulse.
- START:
  - Ignored while BUSY=1.
  - START and ABORT together in IDLE: ABORT wins and nothing starts.
  - START in the same cycle DONE is high: ignored; it must be re-asserted in IDLE.
- Arithmetic: W_DATA is BRAM_DO passed through unchanged, with no sign extension or scaling.

Decomposition:
- Package ann_weight_pkg holds:
  - the constant WEIGHT_W=16;
  - the reader state enum {IDLE, FETCH, DRAIN, DONE_ST};
  - the default DEPTH/AW constants for the weight memories.
- Sub-module weight_skid_fifo:
  - 2-entry FIFO of {DW data, AW index, last}.
  - Ports: push/pop/flush, count, head outputs.
  - Reset asynchronous, active-low, on the same RST_N.

Test Plan:
- Full pass, W_READY=1, BRAM preloaded with value 100+i at address i:
  - START -> W_VALID from cycle 2 with W_DATA 100..127 on 28 consecutive cycles.
  - W_LAST only with W_INDEX=27; DONE pulse one cycle later; BUSY low after.
- Backpressure: W_READY=0 for 6 cycles while index 3 is at the head:
  - W_DATA=103 held stable.
  - BRAM_EN low once fifo_count+inflight=2.
  - Resuming yields 103,104,... with no gap, duplicate or loss.
- Random W_READY (50%, seeded), signed data including 0x8000 and 0x7FFF:
  - Scoreboard sees exactly addresses 0..27 in order with bit-exact values.
  - Exactly one DONE.
- ABORT when W_INDEX=10 is handshaken:
  - Next cycle W_VALID=0, BUSY=0, no DONE.
  - A new START restarts at index 0 and completes normally.
- RST_N low asynchronously mid-DRAIN (between clock edges):
  - All outputs 0 immediately.
  - After release, START gives a clean full pass.
- START pulsed again while BUSY, and START with ABORT in IDLE:
  - Both ignored; the stream is unaffected and no extra pass occurs.
  - Repeat the full-pass check with DEPTH=4, AW=2.
